settings_write_sequencer: RTL

Sequences incoming 16-bit settings words (from the SPI receive path) into the synthesizer settings `memory` block. Each word carries a register address and a 12-bit payload. Words are queued in a small FIFO and applied one at a time, only on audio sample-tick boundaries, so note, carrier, modulator, FM beta, envelope and filter settings never change mid-sample. The block also reports status: which registers have been loaded, overflow, and bad-address errors.

---
 rtl/settings_write_sequencer_if.sv | 31 +++
 rtl/settings_write_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/settings_write_sequencer_if.sv
// Bundles the settings-word input stream and the memory-write/status outputs of
// settings_write_sequencer; clk and rst stay plain ports on the module.
interface settings_write_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_REGS   = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]         wordIn;
    logic                wordValid;
    logic                sampleTick;
    logic                clearFlags;
    logic [15:0]         memData;
    logic                memWe;
    logic [CntW-1:0]     fifoCount;
    logic                busy;
    logic                overflow;
    logic                badAddr;
    logic [NUM_REGS-1:0] loaded;
    logic                configReady;

    modport master (
        output wordIn, wordValid, sampleTick, clearFlags,
        input  memData, memWe, fifoCount, busy, overflow, badAddr, loaded, configReady
    );

    modport slave (
        input  wordIn, wordValid, sampleTick, clearFlags,
        output memData, memWe, fifoCount, busy, overflow, badAddr, loaded, configReady
    );
endinterface

// File: rtl/settings_write_sequencer.sv
// Queues settings words and writes them into the settings memory one per audio sample tick,
// holding memData stable afterwards, while tracking load status and sticky error flags.
module settings_write_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic                         clk,
    input logic                         rst,
    settings_write_sequencer_if.slave   bus
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

    state_e              state_q, state_d;
    logic [15:0]         fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [15:0]         mem_data_q, mem_data_d;
    logic                mem_we_q, mem_we_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic                ovf_q, ovf_d;
    logic                bad_q, bad_d;
    logic [NUM_REGS-1:0] loaded_q, loaded_d;

    logic addr_bad, full, push, pop;

    // Address is judged before fullness so a bad word never counts as an overflow.
    assign addr_bad = 32'(bus.wordIn[15:12]) >= NUM_REGS;
    assign full     = (cnt_q == CntW'(FIFO_DEPTH));
    assign push     = bus.wordValid && !addr_bad && !full;

    always_comb begin
        state_d    = state_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        hold_d     = hold_q;
        loaded_d   = loaded_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.sampleTick && (cnt_q != '0)) begin
                    pop        = 1'b1;
                    mem_data_d = fifo_q[rd_ptr_q];
                    mem_we_d   = 1'b1;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (32'(mem_data_q[15:12]) == k) loaded_d[k] = 1'b1;
                end
                hold_d  = '0;
                state_d = StHold;
            end
            StHold: begin
                if (hold_q == HoldW'(HOLD_CYCLES - 1)) state_d = StIdle;
                else                                  hold_d  = hold_q + HoldW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CntW'(1);
        else if (!push && pop) cnt_d = cnt_q - CntW'(1);
        // A set in the same cycle as clearFlags wins.
        ovf_d = (bus.wordValid && !addr_bad && full) || (ovf_q && !bus.clearFlags);
        bad_d = (bus.wordValid && addr_bad) || (bad_q && !bus.clearFlags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            hold_q     <= '0;
            ovf_q      <= 1'b0;
            bad_q      <= 1'b0;
            loaded_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
            bad_q      <= bad_d;
            loaded_q   <= loaded_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= bus.wordIn;
    end

    assign bus.memData     = mem_data_q;
    assign bus.memWe       = mem_we_q;
    assign bus.fifoCount   = cnt_q;
    assign bus.busy        = (state_q != StIdle) || (cnt_q != '0);
    assign bus.overflow    = ovf_q;
    assign bus.badAddr     = bad_q;
    assign bus.loaded      = loaded_q;
    assign bus.configReady = &loaded_q;
endmodule
